// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer
//   Holds the architectural PC and turns each resolved next-PC decision from
//   execute into an absolute fetch address. Issues instruction-memory reads
//   with at most one outstanding. Keeps a single-entry buffer toward decode
//   with a valid/ready handshake. Redirects flush the buffer and mark any
//   in-flight read as wrong-path so its response is discarded.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   exec_valid            execute presents a resolved instruction
//   next_pc_select        00 PC+4, 01 branch, 10 jalr (bit0 cleared), 11 trap
//   branch_target         PC+imm from execute
//   jalr_target           rs1+imm from execute
//   trap_vector           machine trap handler address
//   imem_req_valid/addr   read request toward instruction memory
//   imem_req_ready        memory accepts the request
//   imem_rsp_valid/data   read response (no backpressure)
//   fetch_valid/pc/inst   buffered instruction toward decode
//   fetch_ready           decode consumes the buffer
//   target_misaligned     one-cycle pulse after a misaligned redirect target
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_REQ  | no read outstanding; may issue when the buffer is free
// S_WAIT | one read outstanding; waiting for imem_rsp_valid

module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exec_valid,
  input  logic [1:0]  next_pc_select,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic [31:0] trap_vector,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst,
  input  logic        fetch_ready,
  output logic        target_misaligned
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] inflight_pc;
  logic [31:0] inflight_pc_nxt;
  logic        kill;
  logic        kill_nxt;
  logic        fetch_valid_nxt;
  logic [31:0] fetch_pc_nxt;
  logic [31:0] fetch_inst_nxt;
  logic        misaligned_nxt;

  logic        req_fire;
  logic        redirect;
  logic [31:0] jalr_clr;
  logic [31:0] sel_target;
  logic        target_bad;
  logic [31:0] redirect_pc;

  // Issue only depends on registered state and the decode drain, never on
  // the execute-side inputs.
  assign imem_req_valid = (state == S_REQ) && (!fetch_valid || fetch_ready);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign redirect = exec_valid && (next_pc_select != 2'b00);
  assign jalr_clr = jalr_target & ~32'h0000_0001;

  always_comb begin
    sel_target = branch_target;
    target_bad = 1'b0;
    case (next_pc_select)
      2'b01: begin
        sel_target = branch_target;
        target_bad = branch_target[1] | branch_target[0];
      end
      2'b10: begin
        sel_target = jalr_clr;
        target_bad = jalr_clr[1];
      end
      2'b11: begin
        // Trap vector alignment is the trap unit's responsibility.
        sel_target = trap_vector;
        target_bad = 1'b0;
      end
      default: begin
        sel_target = branch_target;
        target_bad = 1'b0;
      end
    endcase
  end

  assign redirect_pc = target_bad ? trap_vector : sel_target;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    inflight_pc_nxt = inflight_pc;
    kill_nxt        = kill;
    fetch_valid_nxt = fetch_valid;
    fetch_pc_nxt    = fetch_pc;
    fetch_inst_nxt  = fetch_inst;
    misaligned_nxt  = 1'b0;

    if (fetch_valid && fetch_ready) begin
      fetch_valid_nxt = 1'b0;
    end

    case (state)
      S_REQ: begin
        if (req_fire) begin
          inflight_pc_nxt = pc;
          pc_nxt          = pc + 32'd4;
          state_nxt       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt = S_REQ;
          kill_nxt  = 1'b0;
          // A response landing with a redirect is wrong-path too.
          if (!kill && !redirect) begin
            fetch_valid_nxt = 1'b1;
            fetch_pc_nxt    = inflight_pc;
            fetch_inst_nxt  = imem_rsp_data;
          end
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase

    if (redirect) begin
      pc_nxt          = redirect_pc;
      fetch_valid_nxt = 1'b0;
      misaligned_nxt  = target_bad;
      // Read still in flight (or issued this very cycle): its data is stale.
      if ((state == S_WAIT) && !imem_rsp_valid) begin
        kill_nxt = 1'b1;
      end
      if (req_fire) begin
        kill_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= S_REQ;
      pc                <= RESET_VECTOR;
      inflight_pc       <= RESET_VECTOR;
      kill              <= 1'b0;
      fetch_valid       <= 1'b0;
      fetch_pc          <= 32'h0;
      fetch_inst        <= 32'h0;
      target_misaligned <= 1'b0;
    end else begin
      state             <= state_nxt;
      pc                <= pc_nxt;
      inflight_pc       <= inflight_pc_nxt;
      kill              <= kill_nxt;
      fetch_valid       <= fetch_valid_nxt;
      fetch_pc          <= fetch_pc_nxt;
      fetch_inst        <= fetch_inst_nxt;
      target_misaligned <= misaligned_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer. The memory model returns
// addr + 0x1000_0000 as the instruction word, `lat` cycles after accept.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.

module tb_fetch_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        exec_valid;
  logic [1:0]  next_pc_select;
  logic [31:0] branch_target;
  logic [31:0] jalr_target;
  logic [31:0] trap_vector;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        fetch_ready;
  logic        target_misaligned;

  int          checks = 0;
  int          errors = 0;

  int          lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  logic        inject = 1'b0;

  always #5 clock = ~clock;

  fetch_pc_sequencer #(.RESET_VECTOR(32'h0040_0000)) dut (
    .clock             (clock),
    .reset             (reset),
    .exec_valid        (exec_valid),
    .next_pc_select    (next_pc_select),
    .branch_target     (branch_target),
    .jalr_target       (jalr_target),
    .trap_vector       (trap_vector),
    .imem_req_valid    (imem_req_valid),
    .imem_req_addr     (imem_req_addr),
    .imem_req_ready    (imem_req_ready),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
    .fetch_valid       (fetch_valid),
    .fetch_pc          (fetch_pc),
    .fetch_inst        (fetch_inst),
    .fetch_ready       (fetch_ready),
    .target_misaligned (target_misaligned)
  );

  always @(posedge clock) begin
    if (imem_req_valid && imem_req_ready) begin
      mem_cnt  <= lat;
      mem_addr <= imem_req_addr;
    end else if (mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  assign imem_rsp_valid = (mem_cnt == 1) || inject;
  assign imem_rsp_data  = mem_addr + 32'h1000_0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic redir(input logic [1:0] sel, input logic [31:0] br, input logic [31:0] jr);
    exec_valid     = 1'b1;
    next_pc_select = sel;
    branch_target  = br;
    jalr_target    = jr;
  endtask

  initial begin
    reset          = 1'b1;
    exec_valid     = 1'b0;
    next_pc_select = 2'b00;
    branch_target  = 32'h0;
    jalr_target    = 32'h0;
    trap_vector    = 32'h0000_0100;
    imem_req_ready = 1'b0;
    fetch_ready    = 1'b1;

    cyc(); cyc();
    smp();
    chk("rst_fv", fetch_valid, 0);
    chk("rst_fpc", fetch_pc, 32'h0);
    chk("rst_finst", fetch_inst, 32'h0);
    chk("rst_mis", target_misaligned, 0);
    chk("rst_rqv", imem_req_valid, 1);
    chk("rst_rqa", imem_req_addr, 32'h0040_0000);

    // C0
    cyc(); reset = 1'b0; imem_req_ready = 1'b1;
    smp(); chk("c0_rqa", imem_req_addr, 32'h0040_0000);
    // C1
    cyc(); smp(); chk("c1_rqv", imem_req_valid, 0);
    // C2..C6 decode stalls on the first instruction
    cyc(); fetch_ready = 1'b0;
    smp();
    chk("c2_finst", fetch_inst, 32'h1040_0000);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin
        cyc(); smp();
      end
      chk("stall_rqv", imem_req_valid, 0);
      chk("stall_fv", fetch_valid, 1);
      chk("stall_fpc", fetch_pc, 32'h0040_0000);
    end
    // C7 decode resumes; request issues in the same cycle
    cyc(); fetch_ready = 1'b1;
    smp();
    chk("c7_rqv", imem_req_valid, 1);
    chk("c7_rqa", imem_req_addr, 32'h0040_0004);
    cyc(); smp(); chk("c8_fv", fetch_valid, 0);
    cyc(); smp();
    chk("c9_fpc", fetch_pc, 32'h0040_0004);
    chk("c9_finst", fetch_inst, 32'h1040_0004);
    chk("c9_rqa", imem_req_addr, 32'h0040_0008);
    cyc(); smp(); chk("c10_fv", fetch_valid, 0);
    // C11: third instruction; next read has latency 3
    cyc(); lat = 3;
    smp();
    chk("c11_fpc", fetch_pc, 32'h0040_0008);
    chk("c11_rqa", imem_req_addr, 32'h0040_000C);
    // C12: branch redirect one cycle after accept
    cyc(); redir(2'b01, 32'h0040_0100, 32'h0);
    smp(); chk("c12_rqv", imem_req_valid, 0);
    cyc(); exec_valid = 1'b0;
    smp(); chk("c13_fv", fetch_valid, 0);
    cyc(); smp();
    chk("c14_rsp", imem_rsp_valid, 1);
    chk("c14_fv", fetch_valid, 0);
    cyc(); lat = 1;
    smp();
    chk("c15_fv_drop", fetch_valid, 0);
    chk("c15_rqa", imem_req_addr, 32'h0040_0100);
    cyc(); smp(); chk("c16_fv", fetch_valid, 0);
    // C17: jalr redirect (aligned after bit0 clear) during decode handshake
    cyc(); imem_req_ready = 1'b0; redir(2'b10, 32'h0, 32'h0040_0201);
    smp();
    chk("c17_fpc", fetch_pc, 32'h0040_0100);
    chk("c17_finst", fetch_inst, 32'h1040_0100);
    cyc(); exec_valid = 1'b0; imem_req_ready = 1'b1;
    smp();
    chk("c18_fv", fetch_valid, 0);
    chk("c18_mis", target_misaligned, 0);
    chk("c18_rqa", imem_req_addr, 32'h0040_0200);
    cyc(); smp(); chk("c19_fv", fetch_valid, 0);
    // C20: misaligned jalr coinciding with a request handshake
    cyc(); redir(2'b10, 32'h0, 32'h0040_0202);
    smp();
    chk("c20_fpc", fetch_pc, 32'h0040_0200);
    chk("c20_rqa", imem_req_addr, 32'h0040_0204);
    cyc(); exec_valid = 1'b0;
    smp();
    chk("c21_mis", target_misaligned, 1);
    chk("c21_fv", fetch_valid, 0);
    chk("c21_rqv", imem_req_valid, 0);
    cyc(); smp();
    chk("c22_mis", target_misaligned, 0);
    chk("c22_fv", fetch_valid, 0);
    chk("c22_rqa", imem_req_addr, 32'h0000_0100);
    cyc(); smp(); chk("c23_fv", fetch_valid, 0);
    cyc(); smp();
    chk("c24_fv", fetch_valid, 1);
    chk("c24_fpc", fetch_pc, 32'h0000_0100);
    chk("c24_finst", fetch_inst, 32'h1000_0100);
    // C25: redirect coinciding with response arrival
    cyc(); redir(2'b01, 32'h0040_0300, 32'h0);
    smp(); chk("c25_rsp", imem_rsp_valid, 1);
    cyc(); exec_valid = 1'b0;
    smp();
    chk("c26_fv", fetch_valid, 0);
    chk("c26_rqa", imem_req_addr, 32'h0040_0300);
    cyc(); smp(); chk("c27_fv", fetch_valid, 0);
    // C28: misaligned branch via bit0
    cyc(); imem_req_ready = 1'b0; redir(2'b01, 32'h0040_0301, 32'h0);
    smp(); chk("c28_fpc", fetch_pc, 32'h0040_0300);
    cyc(); redir(2'b00, 32'h0040_0500, 32'h0);
    smp();
    chk("c29_mis", target_misaligned, 1);
    chk("c29_fv", fetch_valid, 0);
    chk("c29_rqa", imem_req_addr, 32'h0000_0100);
    cyc(); exec_valid = 1'b0; next_pc_select = 2'b01;
    smp();
    chk("c30_mis", target_misaligned, 0);
    chk("c30_sel00", imem_req_addr, 32'h0000_0100);
    cyc(); next_pc_select = 2'b00; imem_req_ready = 1'b1; lat = 3;
    smp(); chk("c31_nox", imem_req_addr, 32'h0000_0100);
    // C32: reset while a read is outstanding
    cyc(); reset = 1'b1; imem_req_ready = 1'b0;
    smp(); chk("c32_rqv", imem_req_valid, 0);
    cyc(); reset = 1'b0;
    smp();
    chk("c33_fv", fetch_valid, 0);
    chk("c33_rqv", imem_req_valid, 1);
    chk("c33_rqa", imem_req_addr, 32'h0040_0000);
    cyc(); smp(); chk("c34_stale", imem_rsp_valid, 1);
    cyc(); lat = 1; imem_req_ready = 1'b1;
    smp();
    chk("c35_fv", fetch_valid, 0);
    chk("c35_rqa", imem_req_addr, 32'h0040_0000);
    cyc(); smp();
    // C37: reset while the buffer is full
    cyc(); fetch_ready = 1'b0; imem_req_ready = 1'b0; reset = 1'b1;
    smp(); chk("c37_fv", fetch_valid, 1);
    cyc(); reset = 1'b0; inject = 1'b1;
    smp();
    chk("c38_fv", fetch_valid, 0);
    chk("c38_fpc", fetch_pc, 32'h0);
    chk("c38_finst", fetch_inst, 32'h0);
    chk("c38_rqa", imem_req_addr, 32'h0040_0000);
    cyc(); inject = 1'b0; fetch_ready = 1'b1; redir(2'b01, 32'hFFFF_FFFC, 32'h0);
    smp();
    chk("c39_fv", fetch_valid, 0);
    chk("c39_rqv", imem_req_valid, 1);
    // Wrap of PC+4 at the top of the address space
    cyc(); exec_valid = 1'b0; imem_req_ready = 1'b1;
    smp(); chk("c40_rqa", imem_req_addr, 32'hFFFF_FFFC);
    cyc(); smp();
    cyc(); smp();
    chk("c42_fpc", fetch_pc, 32'hFFFF_FFFC);
    chk("c42_finst", fetch_inst, 32'h0FFF_FFFC);
    chk("c42_wrap", imem_req_addr, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
